// File: rtl/alu_operand_stage.sv
// alu_operand_stage
//   Decode-to-execute pipeline register feeding the 16-bit ALU (in_a, in_b, op).
//   Captures decoded operands, sign-extends the immediate and legalises the
//   opcode. RAW hazards are resolved by forwarding from MEM/WB on the held
//   operands, and WB writes are snooped into the held operands during stalls.
//
// Ports
//   clk, reset                      clock, async active-high reset
//   in_valid / in_ready             decode handshake (in_ready = ~out_valid | ex_ready)
//   id_*                            decoded instruction fields
//   flush                           kill held and incoming instruction
//   ex_ready                        execute consumes the held instruction
//   mem_*, wb_*                     forwarding / snoop sources
//   alu_a, alu_b, alu_op            ALU operands, zero while out_valid=0
//   out_valid, out_rd_addr,
//   out_reg_write                   held instruction status
//   bad_op                          sticky illegal-opcode flag
module alu_operand_stage #(
   parameter int WIDTH = 16,
   parameter int RADDR = 4,
   parameter int IMM_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] id_rs_data,
   input  logic [WIDTH-1:0] id_rt_data,
   input  logic [RADDR-1:0] id_rs_addr,
   input  logic [RADDR-1:0] id_rt_addr,
   input  logic [IMM_W-1:0] id_imm,
   input  logic             id_use_imm,
   input  logic [2:0]       id_op,
   input  logic [RADDR-1:0] id_rd_addr,
   input  logic             id_reg_write,
   input  logic             flush,
   input  logic             ex_ready,
   input  logic [RADDR-1:0] mem_rd_addr,
   input  logic             mem_reg_write,
   input  logic [WIDTH-1:0] mem_result,
   input  logic [RADDR-1:0] wb_rd_addr,
   input  logic             wb_reg_write,
   input  logic [WIDTH-1:0] wb_result,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_op,
   output logic             out_valid,
   output logic [RADDR-1:0] out_rd_addr,
   output logic             out_reg_write,
   output logic             bad_op
);

   // Held instruction. b already holds the sign-extended immediate when use_imm=1.
   typedef struct packed {
      logic [RADDR-1:0] rs_addr;
      logic [RADDR-1:0] rt_addr;
      logic [RADDR-1:0] rd_addr;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             use_imm;
      logic             reg_write;
      logic [2:0]       op;
   } held_t;

   held_t            held;
   logic             capture;
   logic             op_ok;
   logic [2:0]       op_legal;
   logic [WIDTH-1:0] imm_ext;
   logic             snoop_a, snoop_b;
   logic             mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
   logic [WIDTH-1:0] fwd_a, fwd_b;

   assign in_ready = ~out_valid | ex_ready;
   assign capture  = in_valid & in_ready & ~flush;
   assign imm_ext  = {{(WIDTH-IMM_W){id_imm[IMM_W-1]}}, id_imm};

   always_comb begin
      op_ok = 1'b0;
      case (id_op)
         3'd0, 3'd1, 3'd2, 3'd4, 3'd6: op_ok = 1'b1;
         default:                      op_ok = 1'b0;
      endcase
      op_legal = op_ok ? id_op : 3'd2;
   end

   // Register 0 is hardwired: never forwarded, never snooped.
   assign mem_hit_a = mem_reg_write & (mem_rd_addr == held.rs_addr) & (held.rs_addr != '0);
   assign wb_hit_a  = wb_reg_write  & (wb_rd_addr  == held.rs_addr) & (held.rs_addr != '0);
   assign mem_hit_b = mem_reg_write & (mem_rd_addr == held.rt_addr) & (held.rt_addr != '0)
                      & ~held.use_imm;
   assign wb_hit_b  = wb_reg_write  & (wb_rd_addr  == held.rt_addr) & (held.rt_addr != '0)
                      & ~held.use_imm;

   // Snooping keeps the held copy current while the instruction waits, so a
   // WB write that retires mid-stall is not lost once WB moves on.
   assign snoop_a = out_valid & ~capture & wb_hit_a;
   assign snoop_b = out_valid & ~capture & wb_hit_b;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         held      <= '0;
         out_valid <= 1'b0;
         bad_op    <= 1'b0;
      end else begin
         if (flush)        out_valid <= 1'b0;
         else if (capture) out_valid <= 1'b1;
         else if (ex_ready) out_valid <= 1'b0;

         if (capture) begin
            held.rs_addr   <= id_rs_addr;
            held.rt_addr   <= id_rt_addr;
            held.rd_addr   <= id_rd_addr;
            held.a         <= id_rs_data;
            held.b         <= id_use_imm ? imm_ext : id_rt_data;
            held.use_imm   <= id_use_imm;
            held.reg_write <= id_reg_write;
            held.op        <= op_legal;
            if (!op_ok) bad_op <= 1'b1;
         end else begin
            if (snoop_a) held.a <= wb_result;
            if (snoop_b) held.b <= wb_result;
         end
      end
   end

   // MEM is younger than WB, so it wins.
   always_comb begin
      fwd_a = held.a;
      if (mem_hit_a)     fwd_a = mem_result;
      else if (wb_hit_a) fwd_a = wb_result;
      fwd_b = held.b;
      if (mem_hit_b)     fwd_b = mem_result;
      else if (wb_hit_b) fwd_b = wb_result;
   end

   // Idle stage presents zeros with op=AND so the ALU output is deterministic.
   assign alu_a         = out_valid ? fwd_a   : '0;
   assign alu_b         = out_valid ? fwd_b   : '0;
   assign alu_op        = out_valid ? held.op : 3'd0;
   assign out_rd_addr   = held.rd_addr;
   assign out_reg_write = out_valid & held.reg_write;

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;

   typedef struct {
      logic        in_valid;
      logic [15:0] rs_data, rt_data;
      logic [3:0]  rs_addr, rt_addr, rd_addr;
      logic [7:0]  imm;
      logic        use_imm;
      logic [2:0]  op;
      logic        reg_write, flush, ex_ready;
      logic [3:0]  mem_rd;
      logic        mem_rw;
      logic [15:0] mem_res;
      logic [3:0]  wb_rd;
      logic        wb_rw;
      logic [15:0] wb_res;
   } stim_t;

   // Expected instruction as seen by the execute stage.
   typedef struct {
      logic [3:0]  rs, rt, rd;
      logic [15:0] a, b;
      logic        ui, rw;
      logic [2:0]  op;
   } ent_t;

   logic        clk = 1'b0, reset = 1'b1;
   logic        in_valid, in_ready, id_use_imm, id_reg_write, flush, ex_ready;
   logic [15:0] id_rs_data, id_rt_data, mem_result, wb_result, alu_a, alu_b;
   logic [3:0]  id_rs_addr, id_rt_addr, id_rd_addr, mem_rd_addr, wb_rd_addr, out_rd_addr;
   logic [7:0]  id_imm;
   logic [2:0]  id_op, alu_op;
   logic        mem_reg_write, wb_reg_write, out_valid, out_reg_write, bad_op;

   int    n_cmp = 0, n_err = 0;
   ent_t  q[$];
   stim_t cur;
   logic  exp_bad = 1'b0;
   logic  mon_en = 1'b0;

   always #5 clk = ~clk;

   alu_operand_stage dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
      .id_imm(id_imm), .id_use_imm(id_use_imm), .id_op(id_op),
      .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
      .flush(flush), .ex_ready(ex_ready),
      .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
      .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .out_valid(out_valid),
      .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write), .bad_op(bad_op)
   );

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h, want %h", nm, $time, act, exp);
      end
   endtask

   function automatic stim_t idle();
      stim_t s;
      s = '{in_valid: 1'b0, rs_data: 16'h0, rt_data: 16'h0, rs_addr: 4'h0, rt_addr: 4'h0,
            rd_addr: 4'h0, imm: 8'h0, use_imm: 1'b0, op: 3'd0, reg_write: 1'b0,
            flush: 1'b0, ex_ready: 1'b1, mem_rd: 4'h0, mem_rw: 1'b0, mem_res: 16'h0,
            wb_rd: 4'h0, wb_rw: 1'b0, wb_res: 16'h0};
      return s;
   endfunction

   function automatic stim_t rnd();
      stim_t s;
      s.in_valid  = ($urandom_range(3) != 0);
      s.rs_data   = 16'($urandom);
      s.rt_data   = 16'($urandom);
      s.rs_addr   = 4'($urandom_range(7));
      s.rt_addr   = 4'($urandom_range(7));
      s.rd_addr   = 4'($urandom_range(15));
      s.imm       = 8'($urandom);
      s.use_imm   = 1'($urandom_range(1));
      s.op        = 3'($urandom_range(7));
      s.reg_write = 1'($urandom_range(1));
      s.flush     = ($urandom_range(15) == 0);
      s.ex_ready  = ($urandom_range(2) != 0);
      s.mem_rd    = 4'($urandom_range(7));
      s.mem_rw    = 1'($urandom_range(1));
      s.mem_res   = 16'($urandom);
      s.wb_rd     = 4'($urandom_range(7));
      s.wb_rw     = 1'($urandom_range(1));
      s.wb_res    = 16'($urandom);
      return s;
   endfunction

   function automatic logic legal(input logic [2:0] op);
      return op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6};
   endfunction

   // Architectural view of an operand: youngest in-flight writer wins, r0 is constant.
   function automatic logic [15:0] fwd(input logic [3:0] addr, input logic [15:0] held);
      if (addr == 0) return held;
      if (cur.mem_rw && cur.mem_rd == addr) return cur.mem_res;
      if (cur.wb_rw && cur.wb_rd == addr) return cur.wb_res;
      return held;
   endfunction

   task automatic apply(input stim_t s);
      cur = s;
      in_valid = s.in_valid; id_rs_data = s.rs_data; id_rt_data = s.rt_data;
      id_rs_addr = s.rs_addr; id_rt_addr = s.rt_addr; id_rd_addr = s.rd_addr;
      id_imm = s.imm; id_use_imm = s.use_imm; id_op = s.op; id_reg_write = s.reg_write;
      flush = s.flush; ex_ready = s.ex_ready;
      mem_rd_addr = s.mem_rd; mem_reg_write = s.mem_rw; mem_result = s.mem_res;
      wb_rd_addr = s.wb_rd; wb_reg_write = s.wb_rw; wb_result = s.wb_res;
   endtask

   // Driver: drive at negedge+1, push the expected entry at negedge+3 (after the
   // monitor has retired the currently held one).
   task automatic step(input stim_t s);
      logic cap;
      ent_t e;
      @(negedge clk);
      #1;
      apply(s);
      cap = s.in_valid && !s.flush && (q.size() == 0 || s.ex_ready);
      #2;
      if (cap) begin
         e.rs = s.rs_addr; e.rt = s.rt_addr; e.rd = s.rd_addr;
         e.a  = s.rs_data;
         e.b  = s.use_imm ? 16'($signed(s.imm)) : s.rt_data;
         e.ui = s.use_imm; e.rw = s.reg_write;
         e.op = legal(s.op) ? s.op : 3'd2;
         if (!legal(s.op)) exp_bad = 1'b1;
         q.push_back(e);
      end
   endtask

   // Monitor: compare presented outputs at negedge, then retire / snoop the
   // front entry for the coming edge.
   always @(negedge clk) begin
      if (mon_en && !reset) begin
         chk("out_valid", 16'(out_valid), 16'(q.size() != 0));
         chk("in_ready", 16'(in_ready), 16'(q.size() == 0 || cur.ex_ready));
         chk("bad_op", 16'(bad_op), 16'(exp_bad));
         if (q.size() != 0) begin
            chk("alu_a", alu_a, fwd(q[0].rs, q[0].a));
            chk("alu_b", alu_b, q[0].ui ? q[0].b : fwd(q[0].rt, q[0].b));
            chk("alu_op", 16'(alu_op), 16'(q[0].op));
            chk("out_rd_addr", 16'(out_rd_addr), 16'(q[0].rd));
            chk("out_reg_write", 16'(out_reg_write), 16'(q[0].rw));
         end else begin
            chk("alu_a_idle", alu_a, 16'h0);
            chk("alu_b_idle", alu_b, 16'h0);
            chk("alu_op_idle", 16'(alu_op), 16'h0);
            chk("out_reg_write_idle", 16'(out_reg_write), 16'h0);
         end
         #2;
         if (mon_en && q.size() != 0) begin
            if (cur.flush || cur.ex_ready) void'(q.pop_front());
            else if (cur.wb_rw && cur.wb_rd != 0) begin
               if (q[0].rs == cur.wb_rd) q[0].a = cur.wb_res;
               if (!q[0].ui && q[0].rt == cur.wb_rd) q[0].b = cur.wb_res;
            end
         end
      end
   end

   initial begin
      stim_t s;
      apply(idle());
      #3;
      chk("rst_out_valid", 16'(out_valid), 16'h0);
      chk("rst_alu_a", alu_a, 16'h0);
      chk("rst_bad_op", 16'(bad_op), 16'h0);
      chk("rst_in_ready", 16'(in_ready), 16'h1);
      #9 reset = 1'b0;
      mon_en = 1'b1;

      // Plain capture, held with ex_ready=0.
      s = idle(); s.in_valid = 1; s.rs_addr = 3; s.rs_data = 16'h0012;
      s.rt_addr = 4; s.rt_data = 16'h0034; s.op = 3'd2; s.ex_ready = 0;
      step(s); #4;
      chk("plain_a", alu_a, 16'h0012);
      chk("plain_b", alu_b, 16'h0034);
      chk("plain_op", 16'(alu_op), 16'd2);
      chk("plain_valid", 16'(out_valid), 16'h1);

      // Stall with WB snoop on rt=4, other instruction offered but refused.
      s = idle(); s.ex_ready = 0; s.wb_rw = 1; s.wb_rd = 4; s.wb_res = 16'h1234;
      s.in_valid = 1; s.rt_data = 16'hDEAD; s.rt_addr = 9;
      step(s); #4;
      chk("snoop_c1_b", alu_b, 16'h1234);
      s.wb_rw = 0;
      for (int i = 0; i < 2; i++) begin
         step(s); #4;
         chk("snoop_hold_b", alu_b, 16'h1234);
         chk("snoop_in_ready", 16'(in_ready), 16'h0);
      end
      step(idle()); #4;
      chk("release_valid", 16'(out_valid), 16'h0);

      // Forward priority on rs=5.
      s = idle(); s.in_valid = 1; s.rs_addr = 5; s.rs_data = 16'h0555; s.rt_addr = 6;
      s.ex_ready = 0;
      step(s);
      s = idle(); s.ex_ready = 0; s.mem_rw = 1; s.mem_rd = 5; s.mem_res = 16'hAAAA;
      s.wb_rw = 1; s.wb_rd = 5; s.wb_res = 16'hBBBB;
      step(s); #4;
      chk("fwd_mem", alu_a, 16'hAAAA);
      s.mem_rw = 0;
      step(s); #4;
      chk("fwd_wb", alu_a, 16'hBBBB);
      s = idle(); s.in_valid = 1; s.rs_addr = 0; s.rs_data = 16'h0777; s.ex_ready = 1;
      step(s);
      s = idle(); s.ex_ready = 0; s.mem_rw = 1; s.mem_rd = 0; s.mem_res = 16'hCCCC;
      s.wb_rw = 1; s.wb_rd = 0; s.wb_res = 16'hDDDD;
      step(s); #4;
      chk("fwd_r0", alu_a, 16'h0777);

      // Flush beats a simultaneous capture.
      s = idle(); s.flush = 1; s.in_valid = 1; s.ex_ready = 0; s.rs_addr = 2;
      s.rs_data = 16'h0999;
      step(s); #4;
      chk("flush_valid", 16'(out_valid), 16'h0);
      chk("flush_a", alu_a, 16'h0);

      // Immediate with illegal opcode; WB to rt must not touch B.
      s = idle(); s.in_valid = 1; s.imm = 8'hF0; s.use_imm = 1; s.op = 3'd5;
      s.rt_addr = 4; s.ex_ready = 0;
      step(s); #4;
      chk("imm_b", alu_b, 16'hFFF0);
      chk("imm_op", 16'(alu_op), 16'd2);
      chk("imm_bad", 16'(bad_op), 16'h1);
      s = idle(); s.ex_ready = 0; s.wb_rw = 1; s.wb_rd = 4; s.wb_res = 16'h5555;
      s.mem_rw = 1; s.mem_rd = 4; s.mem_res = 16'h6666;
      step(s); #4;
      chk("imm_nofwd_b", alu_b, 16'hFFF0);
      for (int i = 0; i < 10; i++) begin
         s = rnd(); s.in_valid = 1; s.flush = 0; s.ex_ready = 1;
         s.op = (i % 2) ? 3'd4 : 3'd6;
         step(s);
      end
      #4;
      chk("bad_sticky", 16'(bad_op), 16'h1);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) step(rnd());

      // Reset mid-stall: outputs clear without a clock edge.
      s = idle(); s.in_valid = 1; s.rs_addr = 1; s.rs_data = 16'h4321; s.op = 3'd2;
      s.ex_ready = 0;
      step(s); #4;
      mon_en = 1'b0;
      reset = 1'b1;
      #1;
      chk("rstmid_valid", 16'(out_valid), 16'h0);
      chk("rstmid_a", alu_a, 16'h0);
      chk("rstmid_b", alu_b, 16'h0);
      chk("rstmid_op", 16'(alu_op), 16'h0);
      chk("rstmid_bad", 16'(bad_op), 16'h0);
      q.delete();
      exp_bad = 1'b0;
      apply(idle());
      @(negedge clk);
      #1 reset = 1'b0;
      mon_en = 1'b1;
      for (int i = 0; i < 20; i++) step(rnd());
      repeat (2) @(negedge clk);
      #4;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Decode-to-execute pipeline register that sits directly upstream of the 16-bit ALU and drives its in_a, in_b and op inputs.
- Latches the decoded operands, sign-extends the immediate and legalises the ALU opcode.
- Resolves RAW hazards by forwarding from the MEM and WB stages, and snoops writeback while stalled so held operands never go stale.
- Uses a valid/ready handshake with the execute stage and supports pipeline flush.

Parameters:
- WIDTH, 16, datapath width; must match the ALU.
- RADDR, 4, register-address width.
- IMM_W, 8, immediate width before sign extension.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage can accept; equals ~out_valid | ex_ready.
- id_rs_data, id_rt_data  in  WIDTH  register-file read data.
- id_rs_addr, id_rt_addr  in  RADDR  source register addresses.
- id_imm  in  IMM_W  raw immediate.
- id_use_imm  in  1  B operand is the immediate.
- id_op  in  3  ALU opcode: 0 and, 1 or, 2 add, 4 slt, 6 sub.
- id_rd_addr  in  RADDR  destination register.
- id_reg_write  in  1  instruction writes rd.
- flush  in  1  kill held and incoming instruction.
- ex_ready  in  1  execute stage consumes the held instruction this cycle.
- mem_rd_addr  in  RADDR  MEM-stage destination.
- mem_reg_write  in  1  MEM-stage write enable.
- mem_result  in  WIDTH  MEM-stage value.
- wb_rd_addr  in  RADDR  WB-stage destination.
- wb_reg_write  in  1  WB-stage write enable.
- wb_result  in  WIDTH  WB-stage value.
- alu_a, alu_b  out  WIDTH  ALU operands.
- alu_op  out  3  ALU opcode.
- out_valid  out  1  held instruction is valid.
- out_rd_addr  out  RADDR  held destination.
- out_reg_write  out  1  held write enable, gated by out_valid.
- bad_op  out  1  sticky illegal-opcode flag.

Behaviour:
- Reset (asynchronous, active-high; clk rising edge otherwise):
  - All held registers clear to 0.
  - out_valid=0, bad_op=0, out_reg_write=0, out_rd_addr=0.
  - alu_a, alu_b and alu_op read 0.
- Capture condition: capture = in_valid & in_ready & ~flush.
  - On capture, hold rs/rt data and addresses, use_imm, rd, reg_write and the legalised op; out_valid goes to 1.
- Release: if ex_ready and no capture, out_valid goes to 0 on the next edge. Otherwise out_valid and all held fields keep their values (stall).
- Flush: has priority over everything. Next edge out_valid=0, and the incoming instruction is dropped even if in_ready=1.
- Immediate: when use_imm=1, B = sign-extended id_imm (bit IMM_W-1 replicated). Forwarding never applies to B in this case.
- Opcode legalisation:
  - Legal set is {0,1,2,4,6}.
  - Any other opcode is captured as 2 (add), and bad_op sets on that edge and stays set until reset.
- Output forwarding is combinational and applied to the held operands. Priority per operand:
  1. MEM: mem_reg_write & mem_rd_addr==addr & addr!=0
  2. WB: wb_reg_write & wb_rd_addr==addr & addr!=0
  3. held value
- Register 0 always reads as held data and is never forwarded.
- Writeback snoop: every edge while out_valid=1 and not capturing, a held operand whose address matches a WB write (addr!=0) is overwritten with wb_result. This keeps values correct across multi-cycle stalls.
- Output gating: when out_valid=0, alu_a=0, alu_b=0 and alu_op=0, so the ALU sees a deterministic AND of zeros.
- Latency: one cycle from capture to presentation at the ALU. Full throughput with back-to-back captures when ex_ready=1.

Test Plan:
- Reset mid-stall: out_valid=1 holding add, assert reset -> out_valid, alu_a, alu_b and alu_op read 0 immediately without a clock edge; bad_op=0.
- Plain capture: rs=3 (data 0x0012), rt=4 (data 0x0034), op=2, in_valid=1 -> next cycle alu_a=0x0012, alu_b=0x0034, alu_op=2, out_valid=1.
- Forward priority: held rs=5; mem_rd=5 with 0xAAAA and wb_rd=5 with 0xBBBB, both writing -> alu_a=0xAAAA. Drop mem_reg_write -> alu_a=0xBBBB. rs=0 with mem_rd=0 -> held value, no forwarding.
- Stall with snoop: ex_ready=0 for 3 cycles, with a WB write of 0x1234 to rt=4 in cycle 1 and WB idle afterwards -> alu_b=0x1234 persists in cycles 2-3; in_ready=0 throughout.
- Immediate and illegal op: id_imm=0xF0, use_imm=1, op=5 -> alu_b=0xFFF0, alu_op=2, bad_op=1 and still 1 after 10 further legal instructions.
- Flush vs capture: out_valid=1 with flush=1 and in_valid=1 in the same cycle -> next cycle out_valid=0, alu_a=0, nothing captured.
